// File: rtl/sram_bist_ctrl.sv
// Purpose: owns the single SRAM port; passes functional traffic through when idle, runs March C- (10N) on bist_start.
// Latency: functional access is combinational pass-through; BIST takes 2560 op cycles + 1 drain cycle, results 2 cycles after a read.
// Backpressure: func_gnt drops for the whole BIST run (requests are dropped, not queued); bist_abort returns to IDLE next cycle.
//
// Ports: clk/rst_n; bist_start/bist_abort control, bist_busy/bist_done/bist_fail/fail_count/first_fail_* status;
//        func_* functional requester side; sram_* SRAM macro side (read data returns one cycle after a read op).
module sram_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bist_start,
    input  logic              bist_abort,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [2:0]        first_fail_elem,
    input  logic              func_req,
    input  logic              func_we,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_wdata,
    output logic              func_gnt,
    output logic [DATA_W-1:0] func_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;       // March element 0..5
    logic              op_q, op_d;           // 0 = first op of the element at this address, 1 = second
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Read issued in cycle k is checked against sram_rdata in cycle k+1.
    logic              cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;

    logic              fail_q, fail_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;
    logic [2:0]        ffe_q, ffe_d;

    logic              in_run, func_mode, abort_now;
    logic              is_read, last_op, desc, last_addr, next_desc, miscmp;
    logic [DATA_W-1:0] rd_bg, wr_bg;

    // Element decode. Reads are always the first op; E0 is write-only.
    // Background: E1/E3/E5 read 0, E2/E4 read 1; E1/E3 write 1, E0/E2/E4 write 0.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        func_mode = (state_q == ST_IDLE) || (state_q == ST_DONE);
        abort_now = bist_abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        is_read   = (elem_q != 3'd0) && !op_q;
        rd_bg     = {DATA_W{(elem_q == 3'd2) || (elem_q == 3'd4)}};
        wr_bg     = {DATA_W{(elem_q == 3'd1) || (elem_q == 3'd3)}};
        last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
        desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_addr = desc ? (addr_q == '0) : (addr_q == '1);
        // element that follows E2/E3 runs descending, so it starts at the top
        next_desc = (elem_q == 3'd2) || (elem_q == 3'd3);
        miscmp    = cmp_vld_q && (sram_rdata != cmp_exp_q);
    end

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        op_d       = op_q;
        addr_d     = addr_q;
        cmp_vld_d  = 1'b0;
        cmp_exp_d  = cmp_exp_q;
        cmp_addr_d = cmp_addr_q;
        cmp_elem_d = cmp_elem_q;
        fail_d     = fail_q;
        fail_cnt_d = fail_cnt_q;
        ffa_d      = ffa_q;
        ffe_d      = ffe_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    state_d    = ST_RUN;
                    elem_d     = 3'd0;
                    op_d       = 1'b0;
                    addr_d     = '0;
                    fail_d     = 1'b0;
                    fail_cnt_d = '0;
                    ffa_d      = '0;
                    ffe_d      = 3'd0;
                end
            end
            ST_RUN: begin
                if (bist_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_read) begin
                        cmp_vld_d  = 1'b1;
                        cmp_exp_d  = rd_bg;
                        cmp_addr_d = addr_q;
                        cmp_elem_d = elem_q;
                    end
                    if (!last_op) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (!last_addr) begin
                            addr_d = desc ? (addr_q - 1'b1) : (addr_q + 1'b1);
                        end else if (elem_q == 3'd5) begin
                            state_d = ST_DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = next_desc ? '1 : '0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                state_d = bist_abort ? ST_IDLE : ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abort freezes results, including the compare pending in the abort cycle.
        if (miscmp && !abort_now) begin
            fail_d = 1'b1;
            if (fail_cnt_q != {CNT_W{1'b1}}) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
            end
            if (!fail_q) begin
                ffa_d = cmp_addr_q;
                ffe_d = cmp_elem_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            elem_q     <= 3'd0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_exp_q  <= '0;
            cmp_addr_q <= '0;
            cmp_elem_q <= 3'd0;
            fail_q     <= 1'b0;
            fail_cnt_q <= '0;
            ffa_q      <= '0;
            ffe_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_addr_q <= cmp_addr_d;
            cmp_elem_q <= cmp_elem_d;
            fail_q     <= fail_d;
            fail_cnt_q <= fail_cnt_d;
            ffa_q      <= ffa_d;
            ffe_q      <= ffe_d;
        end
    end

    // Port mux. Gating with rst_n keeps the SRAM untouched while reset is held,
    // even if the functional side keeps requesting.
    always_comb begin
        bist_busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        bist_done  = (state_q == ST_DONE);
        func_gnt   = rst_n && func_mode && func_req;
        sram_en    = func_gnt || in_run;
        sram_we    = (func_gnt && func_we) || (in_run && !is_read);
        sram_addr  = func_gnt ? func_addr : (in_run ? addr_q : '0);
        sram_wdata = func_gnt ? func_wdata : ((in_run && !is_read) ? wr_bg : '0);
    end

    assign bist_fail       = fail_q;
    assign fail_count      = fail_cnt_q;
    assign first_fail_addr = ffa_q;
    assign first_fail_elem = ffe_q;
    assign func_rdata      = sram_rdata;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
module tb_sram_bist_ctrl;

    localparam int NOPS    = 2560;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bist_start, bist_abort;
    logic        bist_busy, bist_done, bist_fail;
    logic [10:0] fail_count;
    logic [7:0]  first_fail_addr;
    logic [2:0]  first_fail_elem;
    logic        func_req, func_we, func_gnt;
    logic [7:0]  func_addr;
    logic [3:0]  func_wdata, func_rdata;
    logic        sram_en, sram_we;
    logic [7:0]  sram_addr;
    logic [3:0]  sram_wdata;
    logic [3:0]  srd;

    sram_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .CNT_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .bist_start(bist_start), .bist_abort(bist_abort),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
        .fail_count(fail_count), .first_fail_addr(first_fail_addr), .first_fail_elem(first_fail_elem),
        .func_req(func_req), .func_we(func_we), .func_addr(func_addr), .func_wdata(func_wdata),
        .func_gnt(func_gnt), .func_rdata(func_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(srd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- SRAM with injectable stuck-at faults ----------------
    logic [3:0] smem [256];
    logic [3:0] sa1  [256];
    logic [3:0] sa0  [256];

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) smem[sram_addr] <= sram_wdata;
            else         srd <= (smem[sram_addr] | sa1[sram_addr]) & ~sa0[sram_addr];
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            sa1[i] = 4'h0;
            sa0[i] = 4'h0;
        end
    endtask

    // ---------------- reference: flat list of March C- operations ----------------
    logic       op_we   [NOPS];
    logic [7:0] op_addr [NOPS];
    logic [3:0] op_dat  [NOPS];
    logic [2:0] op_elem [NOPS];
    int         n_built;

    // kind: 0 none, 1 r0, 2 r1, 3 w0, 4 w1
    task automatic build_ops();
        int kind [6][2];
        int a;
        kind = '{'{3, 0}, '{1, 4}, '{2, 3}, '{1, 4}, '{2, 3}, '{1, 0}};
        n_built = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < 256; i++)
                for (int j = 0; j < 2; j++)
                    if (kind[e][j] != 0) begin
                        a = (e == 3 || e == 4) ? 255 - i : i;
                        op_we[n_built]   = (kind[e][j] >= 3);
                        op_dat[n_built]  = (kind[e][j] == 2 || kind[e][j] == 4) ? 4'hF : 4'h0;
                        op_addr[n_built] = a[7:0];
                        op_elem[n_built] = e[2:0];
                        n_built++;
                    end
    endtask

    // ---------------- behavioural model: phase, op index, results ----------------
    int         mph = P_IDLE;
    int         mk = 0;
    int         applied = 0;
    int         target;
    logic [3:0] mm [256];
    logic       e_fail = 1'b0;
    int         e_cnt = 0;
    logic [7:0] e_addr = 8'h00;
    logic [2:0] e_elem = 3'd0;

    function automatic void model_clear();
        e_fail  = 1'b0;
        e_cnt   = 0;
        e_addr  = 8'h00;
        e_elem  = 3'd0;
        applied = 0;
    endfunction

    // Apply one operation of the sequence to the model memory and result log.
    function automatic void step();
        logic [3:0] rd;
        logic [7:0] a;
        a = op_addr[applied];
        if (op_we[applied]) begin
            mm[a] = op_dat[applied];
        end else begin
            rd = (mm[a] | sa1[a]) & ~sa0[a];
            if (rd != op_dat[applied]) begin
                if (!e_fail) begin
                    e_addr = a;
                    e_elem = op_elem[applied];
                end
                e_fail = 1'b1;
                if (e_cnt != 2047) e_cnt++;
            end
        end
        applied++;
    endfunction

    // Results visible in a RUN cycle issuing op k cover ops 0..k-2; DRAIN covers all
    // but the last op, DONE covers all; IDLE keeps whatever was visible.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mph = P_IDLE;
            mk  = 0;
            model_clear();
        end else begin
            case (mph)
                P_IDLE, P_DONE: if (bist_start) begin
                    mph = P_RUN;
                    mk  = 0;
                    model_clear();
                end
                P_RUN: begin
                    if (bist_abort)          mph = P_IDLE;
                    else if (mk == NOPS - 1) mph = P_DRAIN;
                    else                     mk++;
                end
                default: mph = bist_abort ? P_IDLE : P_DONE;
            endcase
            case (mph)
                P_RUN:   target = (mk >= 1) ? mk - 1 : 0;
                P_DRAIN: target = NOPS - 1;
                P_DONE:  target = NOPS;
                default: target = applied;
            endcase
            while (applied < target) step();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic c_fm, c_rn;
    always @(negedge clk) begin
        c_rn = (mph == P_RUN);
        c_fm = (mph == P_IDLE || mph == P_DONE) && (rst_n === 1'b1);
        chk("busy", bist_busy, (mph == P_RUN || mph == P_DRAIN));
        chk("done", bist_done, (mph == P_DONE));
        chk("gnt", func_gnt, c_fm && func_req);
        if (c_rn) begin
            chk("run_en", sram_en, 1);
            chk("run_we", sram_we, op_we[mk]);
            chk("run_addr", sram_addr, op_addr[mk]);
            if (op_we[mk]) chk("run_wdata", sram_wdata, op_dat[mk]);
        end else if (mph == P_DRAIN) begin
            chk("drain_we", sram_we, 0);
        end else if (c_fm && func_req) begin
            chk("fn_en", sram_en, 1);
            chk("fn_we", sram_we, func_we);
            chk("fn_addr", sram_addr, func_addr);
            chk("fn_wdata", sram_wdata, func_wdata);
        end else begin
            chk("quiet_en", sram_en, 0);
            chk("quiet_we", sram_we, 0);
            chk("quiet_addr", sram_addr, 0);
            chk("quiet_wdata", sram_wdata, 0);
        end
        chk("res_fail", bist_fail, e_fail);
        chk("res_cnt", fail_count, e_cnt);
        chk("res_ffa", first_fail_addr, e_addr);
        chk("res_ffe", first_fail_elem, e_elem);
        chk("rdata", func_rdata, srd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_bist();
        @(posedge clk); #1 bist_start = 1'b1;
        @(posedge clk); #1 bist_start = 1'b0;
    endtask

    // Entered in run cycle 1; counts busy cycles and the cycle bist_done first shows.
    task automatic run_to_done(output int busy_c, output int done_c, output int gnt_c);
        busy_c = 0; done_c = 0; gnt_c = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (bist_busy) busy_c++;
            if (bist_busy && func_gnt) gnt_c++;
            if (bist_done) begin
                done_c = c;
                break;
            end
        end
        if (done_c == 0) chk("done_timeout", 0, 1);
    endtask

    int busy_c, done_c, gnt_c, ac, ft, fa, nidle;
    logic [3:0] fmask;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bist_start = 1'b0; bist_abort = 1'b0;
        func_req = 1'b1; func_we = 1'b1; func_addr = 8'h33; func_wdata = 4'h7;
        srd = 4'h0;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 4'h0;
            mm[i]   = 4'h0;
        end
        clear_faults();
        build_ops();

        // pin the op list against the March table
        chk("ops_total", n_built, NOPS);
        chk("op0", {op_we[0], op_addr[0], op_dat[0]}, {1'b1, 8'h00, 4'h0});
        chk("op1", {op_we[1], op_addr[1], op_dat[1]}, {1'b1, 8'h01, 4'h0});
        chk("op256", {op_we[256], op_addr[256], op_dat[256]}, {1'b0, 8'h00, 4'h0});
        chk("op257", {op_we[257], op_addr[257], op_dat[257]}, {1'b1, 8'h00, 4'hF});
        chk("op1280", {op_we[1280], op_addr[1280], op_elem[1280]}, {1'b0, 8'hFF, 3'd3});
        chk("op2559", {op_we[2559], op_addr[2559], op_elem[2559]}, {1'b0, 8'hFF, 3'd5});

        // reset state, with a functional request pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", func_gnt, 0);
        chk("rst_en", sram_en, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_busy", bist_busy, 0);
        chk("rst_cnt", fail_count, 0);
        @(posedge clk); #1 rst_n = 1'b1; func_we = 1'b0;

        // fault-free run with func_req held high
        @(negedge clk);
        chk("gnt_idle", func_gnt, 1);
        @(posedge clk); #1 bist_start = 1'b1;
        @(negedge clk);
        chk("gnt_start", func_gnt, 1);
        @(posedge clk); #1 bist_start = 1'b0;
        run_to_done(busy_c, done_c, gnt_c);
        chk("busy_cycles", busy_c, 2561);
        chk("done_cycle", done_c, 2562);
        chk("gnt_in_run", gnt_c, 0);
        chk("ok_fail", bist_fail, 0);
        chk("ok_cnt", fail_count, 0);
        chk("gnt_done", func_gnt, 1);
        @(posedge clk); #1 func_we = 1'b1; func_addr = 8'h10; func_wdata = 4'hA;
        @(posedge clk); #1 func_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("fn_readback", func_rdata, 4'hA);
        #1 func_req = 1'b0;

        // stuck-at-1 on bit 2 of 0x5A
        sa1[8'h5A] = 4'h4;
        start_bist();
        run_to_done(busy_c, done_c, gnt_c);
        chk("sa1_done", done_c, 2562);
        chk("sa1_fail", bist_fail, 1);
        chk("sa1_cnt", fail_count, 3);
        chk("sa1_addr", first_fail_addr, 8'h5A);
        chk("sa1_elem", first_fail_elem, 1);
        clear_faults();

        // address 0x00 stuck at 0
        sa0[8'h00] = 4'hF;
        start_bist();
        run_to_done(busy_c, done_c, gnt_c);
        chk("sa0_cnt", fail_count, 2);
        chk("sa0_addr", first_fail_addr, 8'h00);
        chk("sa0_elem", first_fail_elem, 2);
        clear_faults();

        // abort at run cycle 1000, then a full rerun
        sa1[8'h05] = 4'h1;
        start_bist();
        repeat (999) @(posedge clk);
        #1 bist_abort = 1'b1;
        @(posedge clk); #1 bist_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", bist_busy, 0);
        chk("abort_done", bist_done, 0);
        chk("abort_en", sram_en, 0);
        chk("abort_cnt", fail_count, 1);
        start_bist();
        run_to_done(busy_c, done_c, gnt_c);
        chk("rerun_busy", busy_c, 2561);
        chk("rerun_cnt", fail_count, 3);
        clear_faults();

        // reset in the middle of a faulty run
        sa1[8'h02] = 4'h8;
        start_bist();
        repeat (499) @(posedge clk);
        #1 rst_n = 1'b0; func_req = 1'b1; func_addr = 8'h77; func_wdata = 4'h5;
        @(negedge clk);
        chk("mrst_busy", bist_busy, 0);
        chk("mrst_fail", bist_fail, 0);
        chk("mrst_cnt", fail_count, 0);
        chk("mrst_gnt", func_gnt, 0);
        chk("mrst_en", sram_en, 0);
        chk("mrst_addr", sram_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_gnt1", func_gnt, 1);
        #1 func_req = 1'b0;
        @(negedge clk);
        chk("post_gnt0", func_gnt, 0);
        clear_faults();

        // randomized runs: random fault, functional noise, stray start/abort, optional abort
        for (int r = 0; r < 6; r++) begin
            clear_faults();
            ft = $urandom_range(0, 2);
            fa = $urandom_range(0, 255);
            fmask = 4'($urandom_range(1, 15));
            if (ft == 1) sa1[fa] = fmask;
            if (ft == 2) sa0[fa] = fmask;
            nidle = $urandom_range(5, 20);
            for (int i = 0; i < nidle; i++) begin
                @(posedge clk); #1;
                func_req   = 1'($urandom_range(0, 1));
                func_we    = 1'($urandom_range(0, 1));
                func_addr  = 8'($urandom_range(0, 255));
                func_wdata = 4'($urandom_range(0, 15));
                bist_abort = ($urandom_range(0, 3) == 0);
            end
            bist_abort = 1'b0;
            start_bist();
            ac = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2561) : 0;
            for (int c = 1; c <= 2601; c++) begin
                if (c == 2601) begin
                    chk("rand_timeout", 0, 1);
                    break;
                end
                func_req   = 1'($urandom_range(0, 1));
                func_we    = 1'($urandom_range(0, 1));
                func_addr  = 8'($urandom_range(0, 255));
                bist_start = (mph == P_RUN && mk < 2500 && $urandom_range(0, 63) == 0);
                bist_abort = (c == ac);
                @(posedge clk); #1;
                if (mph == P_IDLE || mph == P_DONE) break;
            end
            bist_start = 1'b0; bist_abort = 1'b0; func_req = 1'b0; func_we = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
# sram_bist_ctrl

Controller that owns the single port of the 256x4b SRAM and shares it between the functional requester and a built-in March C- test sequencer. In functional mode, requests pass straight through to the SRAM. On `bist_start` it takes the port exclusively, runs the 10N March C- sequence, compares read data, and logs pass/fail, fail count and first-failing location for the top level.

## Interface
- ADDR_W, 8, SRAM address width (depth 2^ADDR_W)
- DATA_W, 4, SRAM word width
- CNT_W, 11, fail counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- bist_start  in  1  start pulse; sampled in IDLE or DONE only
- bist_abort  in  1  abort; honoured in RUN/DRAIN only
- bist_busy  out  1  high in RUN and DRAIN
- bist_done  out  1  high in DONE
- bist_fail  out  1  sticky: at least one miscompare this run
- fail_count  out  CNT_W  number of miscompared read words, saturating at all-ones
- first_fail_addr  out  ADDR_W  address of first miscompare
- first_fail_elem  out  3  March element index (0-5) of first miscompare
- func_req, func_we  in  1  functional access request / write enable
- func_addr  in  ADDR_W; func_wdata  in  DATA_W
- func_gnt  out  1  functional access granted this cycle
- func_rdata  out  DATA_W  equals sram_rdata
- sram_en, sram_we  out  1; sram_addr  out  ADDR_W; sram_wdata  out  DATA_W
- sram_rdata  in  DATA_W  read data, valid one cycle after a read op

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE.
- IDLE/DONE: `func_gnt = func_req` (combinational). SRAM port = functional inputs with `sram_en = func_req`.
- RUN/DRAIN: `func_gnt = 0`. Functional requests are ignored, not queued.
- `bist_start` in IDLE/DONE -> RUN next cycle. It clears `bist_fail`, `fail_count`, `first_fail_*` and deasserts `bist_done`. A functional access in the start cycle is still granted.
- Elements, with background 0 = 4'h0 and 1 = 4'hF:
  - E0 ascending (w0)
  - E1 ascending (r0,w1)
  - E2 ascending (r1,w0)
  - E3 descending (r0,w1)
  - E4 descending (r1,w0)
  - E5 ascending (r0)
- Ascending runs 0..255; descending runs 255..0.
- Per address, each operation takes one cycle, in the listed order. After the last address, the sequencer advances to the next element with no idle cycle.
- Compare: for a read in cycle k, the expected word and element/address are registered. `sram_rdata` is compared in cycle k+1.
- On mismatch:
  - `fail_count` increments, saturating.
  - `bist_fail` sets.
  - `first_fail_addr`/`first_fail_elem` load only if `bist_fail` was 0.
- After the last op (E5 r0 at address 255) -> DRAIN for one cycle (final compare) -> DONE.
- DONE holds results and `bist_done` until the next `bist_start`.
- `bist_abort` in RUN/DRAIN -> IDLE next cycle. `sram_en` is 0 from that cycle. Results freeze, including any compare pending in that cycle, which is discarded. `bist_done` stays 0.
- `bist_abort` in IDLE/DONE is ignored. Abort wins over any other transition.

## Timing
- Reset values:
  - All result outputs 0.
  - `bist_busy`, `bist_done`, `func_gnt`, `sram_en`, `sram_we` = 0.
  - `sram_addr`/`sram_wdata` = 0 unless driven by a functional request.
- rst_n low mid-run: immediate return to reset values. No SRAM access while low.
- Start sampled at edge 0. RUN ops occupy cycles 1..2560 (10x256). DRAIN is cycle 2561. `bist_done` = 1 from cycle 2562.
- `sram_en` = 1 in every RUN cycle. `sram_we` = 1 on w-ops only.
- `fail_count` and `first_fail_*` update at the end of the compare cycle, i.e. visible 2 cycles after the read op.
- Address counter wraps only under sequencer control; no 255->0 wrap occurs within an element.

## Test plan
- Fault-free model:
  - Start -> `bist_busy` high for exactly 2561 cycles.
  - `bist_done` at cycle 2562 with `bist_fail`=0, `fail_count`=0.
  - First six SRAM ops: w0@0, w0@1, ... In E1: r0@0, w1@0.
- Stuck-at-1 on bit 2 of address 0x5A -> `bist_fail`=1, `fail_count`=3 (E1, E3, E5 reads), `first_fail_addr`=0x5A, `first_fail_elem`=1.
- Every cell of address 0x00 stuck at 4'h0 -> `fail_count`=2 (E2, E4), `first_fail_elem`=2, `first_fail_addr`=0x00.
- `func_req` held high throughout:
  - `func_gnt`=1 in IDLE and in the start cycle.
  - `func_gnt`=0 for all of RUN/DRAIN.
  - `func_gnt`=1 again in DONE.
  - Functional write of 4'hA@0x10 in DONE reads back 4'hA.
- `bist_abort` at cycle 1000 -> IDLE at 1001, `sram_en`=0, `bist_done`=0. A following start clears results and runs a full 2560-op sequence.
- Assert rst_n low at cycle 500 of a faulty run -> all outputs at reset values while low. After release, state is IDLE and `func_gnt` follows `func_req`.
